// File: rtl/if_pkg.sv
// Shared defaults and fetch-entry layout for the instruction fetch stage.
package if_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_INSTR_W = 32;
    localparam int unsigned DEF_PC_INC  = 4;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_stage_q_fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries; flush beats push.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_count,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign w_push = i_push && !i_flush;
    assign w_pop  = i_pop && o_valid && !i_flush;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; o_valid gates every read so stale words are never seen.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_fetch_stage_q.sv
// Instruction fetch stage: PC register, credit-based issue to a 1-cycle IMEM,
// redirect/kill handling, and a fetch queue feeding ID via valid/ready.
module if_fetch_stage_q
    import if_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       INSTR_W  = DEF_INSTR_W,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int unsigned       PC_INC   = DEF_PC_INC
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               cPCSrc,
    input  logic [ADDR_W-1:0]  PCSumImm,
    input  logic               cPCMux,
    input  logic [ADDR_W-1:0]  ReadReg1,
    output logic               oIMemReq,
    output logic [ADDR_W-1:0]  oIMemAddr,
    input  logic [INSTR_W-1:0] iIMemData,
    input  logic               iReady,
    output logic               oValid,
    output logic [INSTR_W-1:0] oInstruction,
    output logic [ADDR_W-1:0]  oPC,
    output logic [ADDR_W-1:0]  oPCPlus4
);

    localparam int unsigned       CNT_W      = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] INC        = ADDR_W'(PC_INC);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;

    logic              w_redirect;
    logic [ADDR_W-1:0] w_target_raw;
    logic [ADDR_W-1:0] w_target;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_credit;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_q_valid;
    logic              w_out_valid;
    entry_t            w_push_entry;
    entry_t            w_head;

    assign w_redirect   = cPCMux || cPCSrc;
    assign w_target_raw = cPCMux ? ReadReg1 : PCSumImm;
    assign w_target     = {w_target_raw[ADDR_W-1:2], 2'b00};

    // Entries already queued plus the one still in flight must leave room.
    assign w_credit = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_issue  = !Reset && !w_redirect && (w_credit < CREDIT_MAX);

    assign w_push       = r_inflight && !w_redirect && !Reset;
    assign w_push_entry = '{pc: r_inflight_pc, instr: iIMemData};
    assign w_pop        = w_out_valid && iReady;

    // NOTE: reset outranks redirect, which outranks the sequential increment.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            if (w_redirect) r_pc <= w_target;
            else if (w_issue) r_pc <= r_pc + INC;
            r_inflight <= w_issue;
            if (w_issue) r_inflight_pc <= r_pc;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INSTR_W)
    ) u_fetch_queue (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .i_data  (w_push_entry),
        .o_count (w_count),
        .o_head  (w_head),
        .o_valid (w_q_valid)
    );

    assert property (@(posedge Clk) disable iff (Reset)
        !(w_push && !w_pop && (w_count == CNT_W'(DEPTH))));

    assign w_out_valid  = w_q_valid && !Reset;
    assign oValid       = w_out_valid;
    assign oIMemReq     = w_issue;
    assign oIMemAddr    = r_pc;
    assign oInstruction = w_out_valid ? w_head.instr : '0;
    assign oPC          = w_out_valid ? w_head.pc : '0;
    assign oPCPlus4     = w_out_valid ? (w_head.pc + INC) : '0;

endmodule

// File: tb/tb_if_fetch_stage_q.sv
// Scoreboard bench for if_fetch_stage_q: directed phases push expected entries,
// negedge monitors pop and compare every entry ID accepts.
module tb_if_fetch_stage_q;
    import if_pkg::*;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset, cPCSrc, cPCMux, iReady, oIMemReq, oValid;
    logic [31:0] PCSumImm, ReadReg1, iIMemData, oIMemAddr, oInstruction, oPC, oPCPlus4;

    logic        wReset, wReady, wZero, wReq, wValid;
    logic [31:0] wZeroAddr, wMemData, wAddr, wInstr, wPC, wPCPlus4;

    int n_checks = 0;
    int n_pass   = 0;
    fetch_entry_t sb[$];
    fetch_entry_t sbw[$];

    if_fetch_stage_q #(.DEPTH(4)) u_dut (
        .Clk(Clk), .Reset(Reset), .cPCSrc(cPCSrc), .PCSumImm(PCSumImm),
        .cPCMux(cPCMux), .ReadReg1(ReadReg1), .oIMemReq(oIMemReq),
        .oIMemAddr(oIMemAddr), .iIMemData(iIMemData), .iReady(iReady),
        .oValid(oValid), .oInstruction(oInstruction), .oPC(oPC), .oPCPlus4(oPCPlus4)
    );

    if_fetch_stage_q #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .Clk(Clk), .Reset(wReset), .cPCSrc(wZero), .PCSumImm(wZeroAddr),
        .cPCMux(wZero), .ReadReg1(wZeroAddr), .oIMemReq(wReq),
        .oIMemAddr(wAddr), .iIMemData(wMemData), .iReady(wReady),
        .oValid(wValid), .oInstruction(wInstr), .oPC(wPC), .oPCPlus4(wPCPlus4)
    );

    // Instruction memories: one-cycle latency, data = word index of the address.
    always @(posedge Clk) begin
        iIMemData <= oIMemAddr >> 2;
        wMemData  <= wAddr >> 2;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        sb.push_back('{pc: pc, instr: pc >> 2});
    endtask

    task automatic push_wrap(input logic [31:0] pc);
        sbw.push_back('{pc: pc, instr: pc >> 2});
    endtask

    always @(negedge Clk) begin
        fetch_entry_t e;
        if (!Reset && oValid && iReady && !cPCSrc && !cPCMux) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: accepted pc 0x%08h, expected none", oPC);
            end else begin
                e = sb.pop_front();
                check("sb_pc", oPC, e.pc);
                check("sb_instr", oInstruction, e.instr);
                check("sb_pc4", oPCPlus4, e.pc + 32'd4);
            end
        end
    end

    always @(negedge Clk) begin
        fetch_entry_t e;
        if (!wReset && wValid && wReady) begin
            if (sbw.size() == 0) begin
                n_checks++;
                $display("FAIL wrap_unexpected: accepted pc 0x%08h, expected none", wPC);
            end else begin
                e = sbw.pop_front();
                check("wrap_pc", wPC, e.pc);
                check("wrap_instr", wInstr, e.instr);
                check("wrap_pc4", wPCPlus4, e.pc + 32'd4);
            end
        end
    end

    task automatic wait_drain(input int max, output int n);
        n = 0;
        while (sb.size() != 0 && n < max) begin
            tick();
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    task automatic do_reset(input logic rdy);
        Reset = 1'b1; iReady = rdy; cPCSrc = 1'b0; cPCMux = 1'b0;
        tick();
        check("rst_valid", oValid, 0);
        check("rst_req", oIMemReq, 0);
        tick();
        Reset = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int issues;
        PCSumImm = '0; ReadReg1 = '0;
        wReset = 1'b1; wReady = 1'b0; wZero = 1'b0; wZeroAddr = '0;

        // Stream from reset with ID always ready.
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
        check("s_addr0", oIMemAddr, 32'h0);
        check("s_req0", oIMemReq, 1);
        check("s_valid0", oValid, 0);
        tick();
        check("s_addr1", oIMemAddr, 32'h4);
        check("s_valid1", oValid, 0);
        tick();
        check("s_valid2", oValid, 1);
        check("s_pc2", oPC, 32'h0);
        check("s_pc4_2", oPCPlus4, 32'h4);
        check("s_instr2", oInstruction, 32'h0);
        check("s_addr2", oIMemAddr, 32'h8);
        wait_drain(64, n);
        iReady = 1'b0;
        check("s_cycles", n, 8);

        // Backpressure from reset: exactly DEPTH issues, head held.
        do_reset(1'b0);
        issues = 0;
        for (int i = 0; i < 8; i++) begin
            if (oIMemReq) begin
                check("bp_addr", oIMemAddr, 32'(issues * 4));
                issues++;
            end
            if (i < 7) tick();
        end
        check("bp_issues", issues, 4);
        check("bp_req", oIMemReq, 0);
        check("bp_valid", oValid, 1);
        check("bp_pc", oPC, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
        iReady = 1'b1;
        wait_drain(64, n);
        iReady = 1'b0;
        check("bp_cycles", n, 4);
        tick(); tick(); tick();
        check("bp_full_valid", oValid, 1);
        check("bp_full_pc", oPC, 32'h10);
        check("bp_full_instr", oInstruction, 32'h4);
        check("bp_full_req", oIMemReq, 0);

        // Branch redirect against a full queue, with ID ready in the same cycle.
        cPCSrc = 1'b1; PCSumImm = 32'h100; iReady = 1'b1;
        #1;
        check("br_req_d", oIMemReq, 0);
        for (int i = 0; i < 4; i++) push_exp(32'h100 + 32'(i * 4));
        tick();
        cPCSrc = 1'b0; PCSumImm = '0;
        #1;
        check("br_valid_d1", oValid, 0);
        check("br_addr_d1", oIMemAddr, 32'h100);
        check("br_req_d1", oIMemReq, 1);
        tick();
        check("br_valid_d2", oValid, 0);
        check("br_addr_d2", oIMemAddr, 32'h104);
        tick();
        check("br_valid_d3", oValid, 1);
        check("br_pc_d3", oPC, 32'h100);
        wait_drain(64, n);
        iReady = 1'b0;
        check("br_cycles", n, 4);

        // Jump-register beats branch; target low bits cleared; in-flight killed.
        tick();
        cPCMux = 1'b1; ReadReg1 = 32'h203; cPCSrc = 1'b1; PCSumImm = 32'h400; iReady = 1'b1;
        #1;
        check("pr_req", oIMemReq, 0);
        push_exp(32'h200);
        push_exp(32'h204);
        tick();
        cPCMux = 1'b0; cPCSrc = 1'b0; ReadReg1 = '0; PCSumImm = '0;
        #1;
        check("pr_addr", oIMemAddr, 32'h200);
        check("pr_req1", oIMemReq, 1);
        check("pr_valid1", oValid, 0);
        wait_drain(64, n);
        iReady = 1'b0;
        check("pr_cycles", n, 4);

        // Reset mid-operation with entries queued and a request in flight.
        do_reset(1'b0);
        tick(); tick(); tick(); tick();
        check("mr_pre_valid", oValid, 1);
        Reset = 1'b1;
        #1;
        check("mr_valid", oValid, 0);
        check("mr_req", oIMemReq, 0);
        check("mr_pc", oPC, 32'h0);
        check("mr_instr", oInstruction, 32'h0);
        tick();
        Reset = 1'b0;
        #1;
        check("mr_valid1", oValid, 0);
        check("mr_addr1", oIMemAddr, 32'h0);
        check("mr_req1", oIMemReq, 1);
        tick();
        check("mr_valid2", oValid, 0);
        tick();
        check("mr_valid3", oValid, 1);
        check("mr_pc3", oPC, 32'h0);
        push_exp(32'h0);
        push_exp(32'h4);
        iReady = 1'b1;
        wait_drain(64, n);
        iReady = 1'b0;
        check("mr_cycles", n, 2);

        // PC wrap-around on the second instance.
        tick();
        wReset = 1'b0; wReady = 1'b1;
        #1;
        push_wrap(32'hFFFF_FFF8);
        push_wrap(32'hFFFF_FFFC);
        push_wrap(32'h0);
        check("wr_addr0", wAddr, 32'hFFFF_FFF8);
        check("wr_req0", wReq, 1);
        tick();
        check("wr_addr1", wAddr, 32'hFFFF_FFFC);
        tick();
        check("wr_addr2", wAddr, 32'h0);
        check("wr_pc2", wPC, 32'hFFFF_FFF8);
        tick();
        check("wr_pc3", wPC, 32'hFFFF_FFFC);
        check("wr_pc4_3", wPCPlus4, 32'h0);
        n = 0;
        while (sbw.size() != 0 && n < 64) begin
            tick();
            n++;
        end
        wReady = 1'b0;
        check("wr_cycles", n, 2);

        tick();
        check("sb_empty", sb.size(), 0);
        check("sbw_empty", sbw.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
